// File: rtl/rf_mbist_march_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : rf_mbist_march_ctrl_if
// Brief   : Register-file test port bundle: one write port and two read ports.
// Revision: 1.0
// ============================================================================
interface rf_mbist_march_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0] mem_rd_addr0;
  logic [ADDR_WIDTH-1:0] mem_rd_addr1;
  logic                  mem_wr_en;
  logic                  mem_rd_en0;
  logic                  mem_rd_en1;
  logic [DATA_WIDTH-1:0] mem_data_out0;
  logic [DATA_WIDTH-1:0] mem_data_out1;
  logic                  mem_valid;

  modport master (
    output mem_data_in, mem_wr_addr, mem_rd_addr0, mem_rd_addr1,
    output mem_wr_en, mem_rd_en0, mem_rd_en1,
    input  mem_data_out0, mem_data_out1, mem_valid
  );

  modport slave (
    input  mem_data_in, mem_wr_addr, mem_rd_addr0, mem_rd_addr1,
    input  mem_wr_en, mem_rd_en0, mem_rd_en1,
    output mem_data_out0, mem_data_out1, mem_valid
  );
endinterface
`default_nettype wire

// File: rtl/rf_mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rf_mbist_march_ctrl
// Brief   : March C- BIST controller for a dual-read-port register file.
// Revision: 1.0
// ============================================================================
module rf_mbist_march_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [1:0]            fail_port,
  rf_mbist_march_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] BG_ZERO   = '0;
  localparam logic [DATA_WIDTH-1:0] BG_ONE    = '1;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]            cmp_elem_q, cmp_elem_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [1:0]            fail_port_q, fail_port_d;

  logic                  has_rd, has_wr, descending;
  logic                  rd_cycle, wr_cycle, addr_done, addr_last;
  logic [DATA_WIDTH-1:0] rd_bg, wr_bg;
  logic                  mm0, mm1;
  logic                  wr_en, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Element decode: M0 is write-only, M5 read-only, M1..M4 read-then-write.
  always_comb begin
    has_rd     = (elem_q != 3'd0);
    has_wr     = (elem_q != 3'd5);
    descending = (elem_q >= 3'd3);
    rd_bg      = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? BG_ONE : BG_ZERO;
    wr_bg      = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? BG_ONE : BG_ZERO;
    rd_cycle   = has_rd && !phase_q;
    wr_cycle   = has_wr && (!has_rd || phase_q);
    addr_done  = wr_cycle || !has_wr;
    addr_last  = descending ? (addr_q == '0) : (addr_q == LAST_ADDR);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    cmp_vld_d   = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_port_d = fail_port_q;
    mm0         = 1'b0;
    mm1         = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
    wr_data     = '0;

    // A missing mem_valid is treated as a miscompare on both ports.
    if (cmp_vld_q) begin
      mm0 = !mem.mem_valid || (mem.mem_data_out0 != cmp_exp_q);
      mm1 = !mem.mem_valid || (mem.mem_data_out1 != cmp_exp_q);
      if (mm0 || mm1) begin
        fail_d = 1'b1;
        if (!fail_q) begin
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
          fail_port_d = {mm1, mm0};
        end
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_MARCH;
          elem_d      = 3'd0;
          addr_d      = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          fail_port_d = 2'b00;
        end
      end
      ST_MARCH: begin
        rd_en      = rd_cycle;
        rd_addr    = rd_cycle ? addr_q : '0;
        wr_en      = wr_cycle;
        wr_addr    = wr_cycle ? addr_q : '0;
        wr_data    = wr_cycle ? wr_bg : '0;
        cmp_vld_d  = rd_cycle;
        cmp_exp_d  = rd_bg;
        cmp_addr_d = addr_q;
        cmp_elem_d = elem_q;
        if (has_rd && has_wr) begin
          phase_d = ~phase_q;
        end
        if (addr_done) begin
          if (addr_last) begin
            phase_d = 1'b0;
            if (elem_q == 3'd5) begin
              state_d = ST_DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = (elem_q >= 3'd2) ? LAST_ADDR : '0;
            end
          end else begin
            addr_d = descending ? (addr_q - 1'b1) : (addr_q + 1'b1);
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_port_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_port_q <= fail_port_d;
    end
  end

  assign busy         = (state_q == ST_MARCH) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign fail         = fail_q;
  assign fail_addr    = fail_addr_q;
  assign fail_element = fail_elem_q;
  assign fail_port    = fail_port_q;

  assign mem.mem_data_in  = wr_data;
  assign mem.mem_wr_addr  = wr_addr;
  assign mem.mem_wr_en    = wr_en;
  assign mem.mem_rd_addr0 = rd_addr;
  assign mem.mem_rd_addr1 = rd_addr;
  assign mem.mem_rd_en0   = rd_en;
  assign mem.mem_rd_en1   = rd_en;

endmodule
`default_nettype wire

// File: tb/tb_rf_mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_mbist_march_ctrl
// Brief   : Directed bench for the March C- controller with a faultable RF model.
// Revision: 1.0
// ============================================================================
module tb_rf_mbist_march_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;
  logic [1:0]    fail_port;

  rf_mbist_march_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  rf_mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_element (fail_element),
    .fail_port    (fail_port),
    .mem          (mif)
  );

  always #5 clock = ~clock;

  // Register-file model; faults are applied on the read path only.
  logic [DW-1:0] mem_arr [NW];
  logic [DW-1:0] and_m   [NW];
  logic [DW-1:0] x0_m    [NW];
  logic [DW-1:0] x1_m    [NW];
  int            kill_addr = -1;
  int            trk_cyc = 0;
  int            m0_writes = 0;
  int            first_rd_cyc = 0;
  logic [AW-1:0] first_rd_addr = '0;
  bit            seen_rd = 1'b0;

  always @(posedge clock) begin
    if (mif.mem_wr_en) mem_arr[mif.mem_wr_addr] <= mif.mem_data_in;
    if (mif.mem_rd_en0)
      mif.mem_data_out0 <= (mem_arr[mif.mem_rd_addr0] & and_m[mif.mem_rd_addr0]) ^ x0_m[mif.mem_rd_addr0];
    if (mif.mem_rd_en1)
      mif.mem_data_out1 <= (mem_arr[mif.mem_rd_addr1] & and_m[mif.mem_rd_addr1]) ^ x1_m[mif.mem_rd_addr1];
    mif.mem_valid <= (mif.mem_rd_en0 || mif.mem_rd_en1) && (kill_addr != int'(mif.mem_rd_addr0));
    if (start && !busy) begin
      trk_cyc   <= 1;
      m0_writes <= 0;
      seen_rd   <= 1'b0;
    end else begin
      trk_cyc <= trk_cyc + 1;
      if (mif.mem_wr_en && trk_cyc <= NW) m0_writes <= m0_writes + 1;
      if (mif.mem_rd_en0 && !seen_rd) begin
        seen_rd       <= 1'b1;
        first_rd_cyc  <= trk_cyc;
        first_rd_addr <= mif.mem_rd_addr0;
      end
    end
  end

  typedef struct {
    string      name;
    int         sa0_word;
    int         sa0_bit;
    int         x0_word;
    int         x1_word_a;
    int         x1_word_b;
    int         kill;
    logic       exp_fail;
    logic [3:0] exp_addr;
    logic [2:0] exp_elem;
    logic [1:0] exp_port;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_faults(input vec_t v);
    for (int i = 0; i < NW; i++) begin
      and_m[i] = '1;
      x0_m[i]  = '0;
      x1_m[i]  = '0;
    end
    if (v.sa0_word >= 0)  and_m[v.sa0_word][v.sa0_bit] = 1'b0;
    if (v.x0_word >= 0)   x0_m[v.x0_word]   = 8'h01;
    if (v.x1_word_a >= 0) x1_m[v.x1_word_a] = 8'h01;
    if (v.x1_word_b >= 0) x1_m[v.x1_word_b] = 8'h01;
    kill_addr = v.kill;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; optionally pulses start mid-run.
  task automatic wait_done(input int pulse_at, output int bc);
    bc = 0;
    while (busy === 1'b1 && bc < 400) begin
      bc++;
      start = (bc == pulse_at);
      @(negedge clock);
    end
    start = 1'b0;
    if (bc >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: busy still %0b after %0d cycles, required low", busy, bc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_fail"},  {fail, fail_addr, fail_element, fail_port}, 32'd0);
    chk({tag, "_memo"},  {mif.mem_wr_en, mif.mem_rd_en0, mif.mem_rd_en1, mif.mem_data_in,
                          mif.mem_wr_addr, mif.mem_rd_addr0, mif.mem_rd_addr1}, 32'd0);
  endtask

  initial begin
    int   bc;
    vec_t none;

    //         name        sa0w sa0b x0w x1a x1b kill  fail addr elem port
    vecs[0] = '{"clean",    -1,  0, -1, -1, -1, -1, 1'b0, 4'd0,  3'd0, 2'b00};
    vecs[1] = '{"sa0_w5b3",  5,  3, -1, -1, -1, -1, 1'b1, 4'd5,  3'd2, 2'b11};
    vecs[2] = '{"p1_w9",    -1,  0, -1,  9, -1, -1, 1'b1, 4'd9,  3'd1, 2'b10};
    vecs[3] = '{"p1_w9_w2", -1,  0, -1,  9,  2, -1, 1'b1, 4'd2,  3'd1, 2'b10};
    vecs[4] = '{"p0_w15",   -1,  0, 15, -1, -1, -1, 1'b1, 4'd15, 3'd1, 2'b01};
    vecs[5] = '{"noval_w7", -1,  0, -1, -1, -1,  7, 1'b1, 4'd7,  3'd1, 2'b11};
    none = vecs[0];
    set_faults(none);

    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("idle");

    // Fault-free run: cycle budget, M0 write count and first M1 read slot.
    pulse_start();
    wait_done(0, bc);
    chk("clean_busy_cycles", bc, 161);
    chk("clean_done", {31'd0, done}, 32'd1);
    chk("clean_fail", {31'd0, fail}, 32'd0);
    chk("m0_writes", m0_writes, NW);
    chk("first_rd_cycle", first_rd_cyc, 17);
    chk("first_rd_addr", {28'd0, first_rd_addr}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      set_faults(vecs[i]);
      pulse_start();
      wait_done(0, bc);
      chk({vecs[i].name, "_cycles"}, bc, 161);
      chk({vecs[i].name, "_done"}, {31'd0, done}, 32'd1);
      chk({vecs[i].name, "_fail"}, {31'd0, fail}, {31'd0, vecs[i].exp_fail});
      chk({vecs[i].name, "_addr"}, {28'd0, fail_addr}, {28'd0, vecs[i].exp_addr});
      chk({vecs[i].name, "_elem"}, {29'd0, fail_element}, {29'd0, vecs[i].exp_elem});
      chk({vecs[i].name, "_port"}, {30'd0, fail_port}, {30'd0, vecs[i].exp_port});
    end

    // Restart after a failing run with the fault removed: result clears on accept.
    set_faults(none);
    pulse_start();
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_clr", {fail, fail_addr, fail_element, fail_port}, 32'd0);
    wait_done(0, bc);
    chk("restart_cycles", bc, 161);
    chk("restart_result", {30'd0, done, fail}, 32'd2);

    // start while busy is ignored: the run length is unchanged.
    pulse_start();
    wait_done(40, bc);
    chk("ign_start_cycles", bc, 161);
    chk("ign_start_done", {31'd0, done}, 32'd1);

    // Reset mid-M3 (M3 spans busy cycles 81..112), with a stray start before it.
    pulse_start();
    repeat (84) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("midrun_rd_en", {31'd0, mif.mem_rd_en0 | mif.mem_wr_en}, 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("post_reset");
    pulse_start();
    wait_done(0, bc);
    chk("post_reset_cycles", bc, 161);
    chk("post_reset_result", {30'd0, done, fail}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
